// File: rtl/dsram_like_responder.sv
// Slave end of the data_sram req/addr_ok/data_ok handshake: fixed-latency, in-order responses
// served from a word-organised byte-writable memory array.
module dsram_like_responder #(
  parameter int unsigned MEM_AW = 10,
  parameter int unsigned LAT    = 2,
  parameter int unsigned DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  input  logic        addr_stall,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        proto_err
);

  localparam int unsigned PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CNT_INIT = 4'(LAT - 1);
  localparam logic [2:0]  DEPTH_C  = 3'(DEPTH);

  logic [DEPTH-1:0] valid_q;
  logic [3:0]       cnt_q   [DEPTH];
  logic [31:0]      rdata_q [DEPTH];
  logic [PW-1:0]    head_q, tail_q;
  logic [2:0]       count_q;
  logic             proto_err_q;

  logic [31:0]       mem [2**MEM_AW];
  logic [MEM_AW-1:0] mem_idx;
  logic [31:0]       rd_word;

  logic       pop;
  logic       accept;
  logic [3:0] lane_strb;
  logic       bad_req;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign mem_idx = data_sram_addr[MEM_AW+1:2];
  assign rd_word = mem[mem_idx];

  always_comb begin
    pop               = valid_q[head_q] && (cnt_q[head_q] == 4'd0);
    data_sram_addr_ok = data_sram_req && !addr_stall && ((count_q < DEPTH_C) || pop);
    accept            = data_sram_req && data_sram_addr_ok;
    data_sram_data_ok = pop;
    data_sram_rdata   = pop ? rdata_q[head_q] : 32'd0;
    proto_err         = proto_err_q;
  end

  // Expected byte lanes for a well-formed access of the requested size at this address.
  always_comb begin
    lane_strb = 4'b0000;
    unique case (data_sram_size)
      2'd0:    lane_strb = 4'b0001 << data_sram_addr[1:0];
      2'd1:    lane_strb = data_sram_addr[1] ? 4'b1100 : 4'b0011;
      2'd2:    lane_strb = 4'b1111;
      default: lane_strb = 4'b0000;
    endcase
    bad_req = (data_sram_size == 2'd3)
           || ((data_sram_size == 2'd1) && data_sram_addr[0])
           || ((data_sram_size == 2'd2) && (data_sram_addr[1:0] != 2'd0))
           || (data_sram_wr && (data_sram_wstrb == 4'b0000))
           || (data_sram_wr && (data_sram_wstrb != lane_strb));
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= 3'd0;
      proto_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (valid_q[i] && (cnt_q[i] != 4'd0)) begin
          cnt_q[i] <= cnt_q[i] - 4'd1;
        end
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= ptr_inc(head_q);
      end
      // When full, the slot being popped is the one being refilled; the later write wins.
      if (accept) begin
        valid_q[tail_q] <= 1'b1;
        cnt_q[tail_q]   <= CNT_INIT;
        rdata_q[tail_q] <= data_sram_wr ? 32'd0 : rd_word;
        tail_q          <= ptr_inc(tail_q);
      end
      unique case ({accept, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
      if (accept && bad_req) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wstrb[b]) begin
          mem[mem_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dsram_like_responder.sv
// Scoreboard bench for dsram_like_responder: driver pushes expected responses from a
// byte-level memory model; a negedge monitor pops and checks data and arrival cycle.
module tb_dsram_like_responder;

  localparam int unsigned MEM_AW = 10;
  localparam int unsigned LAT    = 2;
  localparam int unsigned DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [3:0]  wstrb = 4'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        addr_stall = 1'b0;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        proto_err;

  dsram_like_responder #(
    .MEM_AW (MEM_AW),
    .LAT    (LAT),
    .DEPTH  (DEPTH)
  ) dut (
    .clk               (clk),
    .rstn              (rstn),
    .data_sram_req     (req),
    .data_sram_wr      (wr),
    .data_sram_size    (size),
    .data_sram_wstrb   (wstrb),
    .data_sram_addr    (addr),
    .data_sram_wdata   (wdata),
    .addr_stall        (addr_stall),
    .data_sram_addr_ok (addr_ok),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata),
    .proto_err         (proto_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mem_m [2**MEM_AW];
  logic [31:0] exp_q [$];
  int          due_q [$];
  int          last_due = 0;
  bit          exp_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_bad(input logic w, input logic [1:0] s, input logic [3:0] st,
                                input logic [31:0] a);
    logic [3:0] lane;
    case (s)
      2'd0:    lane = 4'b0001 << a[1:0];
      2'd1:    lane = a[1] ? 4'b1100 : 4'b0011;
      2'd2:    lane = 4'b1111;
      default: lane = 4'b0000;
    endcase
    return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0) ||
           (w && (st == 4'd0 || st != lane));
  endfunction

  // Reference: apply the access to the model memory and queue the response it owes.
  task automatic model_accept(input logic w, input logic [1:0] s, input logic [3:0] st,
                              input logic [31:0] a, input logic [31:0] d);
    int idx;
    int due;
    idx = int'((a >> 2) % (32'd1 << MEM_AW));
    if (w) begin
      for (int b = 0; b < 4; b++) if (st[b]) mem_m[idx][8*b +: 8] = d[8*b +: 8];
      exp_q.push_back(32'd0);
    end else begin
      exp_q.push_back(mem_m[idx]);
    end
    due = cyc + int'(LAT);
    if (last_due + 1 > due) due = last_due + 1;
    due_q.push_back(due);
    last_due = due;
    if (is_bad(w, s, st, a)) exp_err = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic w, input logic [1:0] s, input logic [3:0] st,
                       input logic [31:0] a, input logic [31:0] d, input bit rnd_stall,
                       output int acc_cyc);
    int budget;
    budget  = 0;
    acc_cyc = -1;
    req = 1'b1; wr = w; size = s; wstrb = st; addr = a; wdata = d;
    while (acc_cyc < 0 && budget < 100) begin
      addr_stall = rnd_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(negedge clk);
      if (addr_stall && addr_ok) check("addr_ok_under_stall", {31'd0, addr_ok}, 32'd0);
      if (addr_ok) begin
        acc_cyc = cyc;
        model_accept(w, s, st, a, d);
      end
      @(posedge clk);
      #1;
      budget++;
    end
    req = 1'b0;
    addr_stall = 1'b0;
    if (acc_cyc < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: no addr_ok, expected acceptance for addr 0x%08h", a);
    end else begin
      check("proto_err", {31'd0, proto_err}, {31'd0, exp_err});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 50) begin
      @(posedge clk);
      #1;
      b++;
    end
    check("drain_outstanding", exp_q.size(), 32'd0);
  endtask

  // Monitor: every data_ok must match the oldest expected response, on its due cycle.
  always @(negedge clk) begin
    if (rstn && data_ok) begin
      if (exp_q.size() == 0) begin
        check("unexpected_data_ok", {31'd0, data_ok}, 32'd0);
      end else begin
        check("resp_rdata", rdata, exp_q.pop_front());
        check("resp_cycle", cyc, due_q.pop_front());
      end
    end
  end

  initial begin
    int a1, a2, a3, t, rel;
    logic        w;
    logic [1:0]  s;
    logic [3:0]  st;
    logic [31:0] a, d, r;

    rstn = 1'b0;
    idle(3);
    check("reset_data_ok", {31'd0, data_ok}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_proto_err", {31'd0, proto_err}, 32'd0);
    check("reset_addr_ok_idle", {31'd0, addr_ok}, 32'd0);
    rstn = 1'b1;
    idle(1);

    for (int i = 0; i < 16; i++) issue(1'b1, 2'd2, 4'hF, 32'h100 + 32'(4 * i), $urandom, 1'b0, t);
    drain();

    // Word store then load
    issue(1'b1, 2'd2, 4'hF, 32'h100, 32'h1234_5678, 1'b0, t);
    drain();
    issue(1'b0, 2'd2, 4'h0, 32'h100, 32'h0, 1'b0, t);
    drain();

    // Byte and half stores merged into the word
    issue(1'b1, 2'd0, 4'b1000, 32'h103, 32'hABAB_ABAB, 1'b0, t);
    issue(1'b0, 2'd2, 4'h0, 32'h100, 32'h0, 1'b0, t);
    issue(1'b1, 2'd1, 4'b1100, 32'h102, 32'hBEEF_BEEF, 1'b0, t);
    issue(1'b0, 2'd2, 4'h0, 32'h100, 32'h0, 1'b0, t);
    drain();

    // Three back-to-back loads against a two-deep queue
    issue(1'b0, 2'd2, 4'h0, 32'h104, 32'h0, 1'b0, a1);
    issue(1'b0, 2'd2, 4'h0, 32'h108, 32'h0, 1'b0, a2);
    issue(1'b0, 2'd2, 4'h0, 32'h10C, 32'h0, 1'b0, a3);
    check("b2b_second_accept", a2 - a1, 32'd1);
    check("b2b_third_accept", a3 - a1, LAT);
    drain();

    // Held request under stall
    req = 1'b1; wr = 1'b0; size = 2'd2; wstrb = 4'h0; addr = 32'h110; addr_stall = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_addr_ok", {31'd0, addr_ok}, 32'd0);
      check("stall_data_ok", {31'd0, data_ok}, 32'd0);
      @(posedge clk);
      #1;
    end
    addr_stall = 1'b0;
    rel = cyc;
    issue(1'b0, 2'd2, 4'h0, 32'h110, 32'h0, 1'b0, t);
    check("stall_release_accept", t, rel);
    drain();

    // Misaligned word store raises sticky proto_err but still completes
    issue(1'b1, 2'd2, 4'hF, 32'h102, 32'hCAFE_F00D, 1'b0, t);
    drain();
    issue(1'b0, 2'd2, 4'h0, 32'h100, 32'h0, 1'b0, t);
    drain();
    check("proto_err_sticky", {31'd0, proto_err}, 32'd1);

    // Reset with two loads outstanding
    issue(1'b0, 2'd2, 4'h0, 32'h114, 32'h0, 1'b0, t);
    issue(1'b0, 2'd2, 4'h0, 32'h118, 32'h0, 1'b0, t);
    rstn = 1'b0;
    exp_q.delete();
    due_q.delete();
    last_due = 0;
    exp_err = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    check("post_reset_proto_err", {31'd0, proto_err}, 32'd0);
    rel = cyc;
    issue(1'b1, 2'd2, 4'hF, 32'h11C, 32'h5A5A_0F0F, 1'b0, t);
    check("post_reset_accept", t, rel);
    issue(1'b0, 2'd2, 4'h0, 32'h100, 32'h0, 1'b0, t);
    issue(1'b0, 2'd2, 4'h0, 32'h11C, 32'h0, 1'b0, t);
    drain();

    // Randomised traffic over the initialised window
    for (int n = 0; n < 150; n++) begin
      w = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 2));
      r = $urandom;
      case (s)
        2'd0:    begin a = 32'($urandom_range(0, 3)); d = {4{r[7:0]}};  st = 4'b0001 << a[1:0]; end
        2'd1:    begin a = 32'(2 * $urandom_range(0, 1)); d = {2{r[15:0]}};
                       st = a[1] ? 4'b1100 : 4'b0011; end
        default: begin a = 32'd0; d = r; st = 4'hF; end
      endcase
      a = a + 32'h100 + 32'(4 * $urandom_range(0, 15));
      if (w && $urandom_range(0, 15) == 0) st = 4'($urandom_range(0, 15));
      if (!w) st = 4'h0;
      issue(w, s, st, a, d, 1'b1, t);
      idle($urandom_range(0, 2));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
